// File: rtl/uart_tx_if.sv
// Host-side byte interface and serial outputs of the UART transmitter.
interface uart_tx_if;
  logic [7:0] host_din;
  logic       host_we;
  logic       host_dir;
  logic       txd;
  logic       tx_busy;

  modport master (
    output host_din,
    output host_we,
    input  host_dir,
    input  txd,
    input  tx_busy
  );

  modport slave (
    input  host_din,
    input  host_we,
    output host_dir,
    output txd,
    output tx_busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: FIFOSZ-entry holding buffer feeding an 8N1 serializer.
// All state updates on the falling edge of clk; reset_b is synchronous.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned CLKDIV = 16,
  parameter int unsigned FIFOSZ = 2
) (
  input  logic     clk,
  input  logic     reset_b,
  uart_tx_if.slave bus
);

  localparam int unsigned PW = $clog2(FIFOSZ);
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFOSZ-1:0] valid_q, valid_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic            dir_q, dir_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic [7:0]      mem [FIFOSZ];
  logic            accept;
  logic            pop;
  logic            bit_end;

  // Next-state: buffer bookkeeping, frame sequencing and registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    pop      = 1'b0;
    accept   = bus.host_we && !valid_q[wr_ptr_q];
    bit_end  = (cnt_q == '0);

    case (state_q)
      IDLE: begin
        if (valid_q[rd_ptr_q]) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = RELOAD;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          cnt_d   = RELOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = RELOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (valid_q[rd_ptr_q]) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pop and write never target the same entry: a full slot blocks the
    // write, an empty slot blocks the pop.
    if (pop) begin
      state_d            = START;
      cnt_d              = RELOAD;
      shift_d            = mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      par_d              = ^mem[rd_ptr_q];
`endif
      valid_d[rd_ptr_q]  = 1'b0;
      rd_ptr_d           = rd_ptr_q + PW'(1);
    end
    if (accept) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end

    // Line output follows the pre-edge state, giving the two-edge latency.
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = par_q;
`endif
      default: txd_d = 1'b1;
    endcase

    busy_d = (state_q != IDLE) || (state_d != IDLE) || (|valid_d);
    dir_d  = ~(&valid_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(negedge clk) begin
    if (!reset_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      dir_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      dir_q    <= dir_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Buffer storage; contents are qualified by valid bits so no reset needed.
  always_ff @(negedge clk) begin
    if (accept) mem[wr_ptr_q] <= bus.host_din;
  end

  assign bus.txd      = txd_q;
  assign bus.tx_busy  = busy_q;
  assign bus.host_dir = dir_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed host writes, a line decoder per
// instance, and per-instance queues of expected bytes.
module tb_uart_tx;

  localparam int unsigned CLKDIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif
  localparam int unsigned FL = NB * CLKDIV;

  logic clk;
  logic reset_b;

  uart_tx_if bus_a ();
  uart_tx_if bus_b ();

  uart_tx #(.CLKDIV(CLKDIV), .FIFOSZ(2)) dut_a (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus_a)
  );

  uart_tx #(.CLKDIV(CLKDIV), .FIFOSZ(4)) dut_b (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] expq_a [$];
  logic [7:0] expq_b [$];

  int   act    [2];
  int   n      [2];
  int   gap    [2];
  int   frames [2];
  int   nogap  [2];
  logic samp   [2][FL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decode one captured frame and compare it with the oldest expected byte.
  task automatic check_frame(input int i);
    logic       ok;
    logic [7:0] got;
    logic [7:0] exp;
    logic       have;
    ok = 1'b1;
    for (int b = 0; b < int'(NB); b++)
      for (int k = 1; k < int'(CLKDIV); k++)
        if (samp[i][b*CLKDIV+k] !== samp[i][b*CLKDIV]) ok = 1'b0;
    for (int j = 0; j < 8; j++) got[j] = samp[i][(j+1)*CLKDIV];
    chk("bit_timing", 32'(ok), 32'd1);
    chk("stop_bit", 32'(samp[i][(NB-1)*CLKDIV]), 32'd1);
    exp = 8'h00;
    if (i == 0) begin
      have = (expq_a.size() > 0);
      if (have) exp = expq_a.pop_front();
    end else begin
      have = (expq_b.size() > 0);
      if (have) exp = expq_b.pop_front();
    end
    chk("frame_expected", 32'(have), 32'd1);
    if (have) begin
      chk("frame_data", 32'(got), 32'(exp));
`ifdef UART_TX_PARITY_EN
      chk("parity_bit", 32'(samp[i][9*CLKDIV]), 32'(^exp));
`endif
    end
    frames[i]++;
  endtask

  task automatic mon_step(input int i, input logic t);
    if (reset_b !== 1'b1) begin
      act[i] = 0;
      n[i]   = 0;
      gap[i] = 0;
    end else if (act[i] == 0) begin
      if (t === 1'b0) begin
        act[i]     = 1;
        samp[i][0] = t;
        n[i]       = 1;
        if (gap[i] == 0) nogap[i]++;
      end else begin
        gap[i]++;
      end
    end else begin
      samp[i][n[i]] = t;
      n[i]++;
      if (n[i] == int'(FL)) begin
        check_frame(i);
        act[i] = 0;
        n[i]   = 0;
        gap[i] = 0;
      end
    end
  endtask

  // Line samples are taken on the rising edge, midway between DUT updates.
  always @(posedge clk) begin
    mon_step(0, bus_a.txd);
    mon_step(1, bus_b.txd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic busy_of(input int which);
    return (which == 0) ? bus_a.tx_busy : bus_b.tx_busy;
  endfunction

  task automatic wait_idle(input int which, input int budget, input string tag);
    int k;
    k = 0;
    while (busy_of(which) === 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic write_a(input logic [7:0] b);
    bus_a.host_din = b;
    bus_a.host_we  = 1'b1;
    tick();
    bus_a.host_we  = 1'b0;
  endtask

  int f0;
  int g0;
  int wr;
  int k;

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; n[i] = 0; gap[i] = 0; frames[i] = 0; nogap[i] = 0;
    end
    reset_b        = 1'b0;
    bus_a.host_we  = 1'b0;
    bus_a.host_din = 8'h00;
    bus_b.host_we  = 1'b0;
    bus_b.host_din = 8'h00;
    repeat (3) tick();
    chk("rst_txd_a",  32'(bus_a.txd),      32'd1);
    chk("rst_busy_a", 32'(bus_a.tx_busy),  32'd0);
    chk("rst_dir_a",  32'(bus_a.host_dir), 32'd1);
    chk("rst_txd_b",  32'(bus_b.txd),      32'd1);
    chk("rst_busy_b", 32'(bus_b.tx_busy),  32'd0);
    chk("rst_dir_b",  32'(bus_b.host_dir), 32'd1);
    reset_b = 1'b1;
    tick();

    // Single frame and write-to-start latency.
    expq_a.push_back(8'hA5);
    write_a(8'hA5);
    chk("lat_e0_txd",  32'(bus_a.txd),     32'd1);
    chk("lat_e0_busy", 32'(bus_a.tx_busy), 32'd1);
    tick();
    chk("lat_e1_txd", 32'(bus_a.txd), 32'd1);
    tick();
    chk("lat_e2_txd", 32'(bus_a.txd), 32'd0);
    wait_idle(0, 200, "idle_single");
    chk("frames_single", 32'(frames[0]), 32'd1);
    chk("txd_idle", 32'(bus_a.txd), 32'd1);

    // Consecutive writes into a two-entry buffer; the fourth is dropped.
    f0 = frames[0];
    g0 = nogap[0];
    expq_a.push_back(8'h11);
    expq_a.push_back(8'h22);
    expq_a.push_back(8'h33);
    bus_a.host_we  = 1'b1;
    bus_a.host_din = 8'h11;
    tick();
    chk("dir_after_11", 32'(bus_a.host_dir), 32'd1);
    bus_a.host_din = 8'h22;
    tick();
    chk("dir_after_22", 32'(bus_a.host_dir), 32'd1);
    bus_a.host_din = 8'h33;
    tick();
    chk("dir_full", 32'(bus_a.host_dir), 32'd0);
    bus_a.host_din = 8'h44;
    tick();
    bus_a.host_we  = 1'b0;
    chk("dir_after_drop", 32'(bus_a.host_dir), 32'd0);
    wait_idle(0, 400, "idle_burst");
    chk("frames_burst", 32'(frames[0] - f0), 32'd3);
    chk("back_to_back", 32'(nogap[0] - g0), 32'd2);
    chk("queue_empty_burst", 32'(expq_a.size()), 32'd0);

    // Parity-sensitive bytes (parity bit checked when the feature is built in).
    f0 = frames[0];
    expq_a.push_back(8'hA5);
    write_a(8'hA5);
    wait_idle(0, 200, "idle_a5");
    expq_a.push_back(8'h07);
    write_a(8'h07);
    wait_idle(0, 200, "idle_07");
    chk("frames_parity", 32'(frames[0] - f0), 32'd2);

    // Reset during the third data bit of 0x3C with 0x55 buffered.
    f0 = frames[0];
    bus_a.host_din = 8'h3C;
    bus_a.host_we  = 1'b1;
    tick();
    bus_a.host_din = 8'h55;
    tick();
    bus_a.host_we  = 1'b0;
    repeat (13) tick();
    chk("pre_rst_txd", 32'(bus_a.txd), 32'(1'b1));
    reset_b = 1'b0;
    tick();
    chk("abort_txd",  32'(bus_a.txd),      32'd1);
    chk("abort_dir",  32'(bus_a.host_dir), 32'd1);
    chk("abort_busy", 32'(bus_a.tx_busy),  32'd0);
    reset_b = 1'b1;
    repeat (60) tick();
    chk("no_resend_frames", 32'(frames[0] - f0), 32'd0);
    chk("no_resend_busy",   32'(bus_a.tx_busy),  32'd0);
    expq_a.push_back(8'h96);
    write_a(8'h96);
    wait_idle(0, 200, "idle_after_rst");
    chk("frames_after_rst", 32'(frames[0] - f0), 32'd1);
    chk("queue_empty_rst",  32'(expq_a.size()),  32'd0);

    // Four-entry buffer: twelve bytes written as space permits.
    wr = 0;
    k  = 0;
    while (wr < 12 && k < 3000) begin
      if (bus_b.host_dir === 1'b1) begin
        bus_b.host_din = 8'(8'h30 + 7 * wr);
        bus_b.host_we  = 1'b1;
        expq_b.push_back(8'(8'h30 + 7 * wr));
        wr++;
      end else begin
        bus_b.host_we = 1'b0;
      end
      tick();
      k++;
    end
    bus_b.host_we = 1'b0;
    chk("wrap_writes", 32'(wr), 32'd12);
    wait_idle(1, 1500, "idle_wrap");
    chk("frames_wrap",      32'(frames[1]),     32'd12);
    chk("queue_empty_wrap", 32'(expq_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
